ex_mem_stage_rv32i: RTL

- Execute-to-memory pipeline stage of the RV32I core, directly downstream of the ALU adder.
- Captures the adder result plus store data and control, and presents them to the memory stage through a valid/ready handshake.
- Has a 2-entry skid buffer so `ex_ready` is a registered signal.
- Also drives the forwarding path (`fwd_*`) back to the adder's operand muxes.

---
 rtl/ex_mem_stage_rv32i.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage_rv32i.sv
// ex_mem_stage_rv32i
// Execute-to-memory pipeline register of the RV32I core, placed directly after
// the ALU adder. A two-entry skid buffer lets ex_ready come straight from a flop.
// The forwarding port (fwd_*) returns the head entry's result to the adder's
// operand muxes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ex_valid/ex_ready  upstream handshake (ex_ready is registered)
//   ex_*               upstream payload: result, store data, rd, control, funct3
//   flush              drops every held entry and the entry offered this cycle
//   mem_valid/ready    downstream handshake; mem_* carry the head entry
//   fwd_valid/rd/data  forwarding candidate taken from the head entry
//   stall_cnt          present only when EXMEM_STALL_CNT_EN is defined; a
//                      saturating count of cycles with mem_valid & !mem_ready
//
// Optional feature macro: EXMEM_STALL_CNT_EN
module ex_mem_stage_rv32i #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_out,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_alu_out,
  output logic [XLEN-1:0]   mem_rs2_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [2:0]        mem_funct3,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
  } entry_t;

  state_e state_q, state_d;
  entry_t h_q, h_d;   // head entry, drives mem_*
  entry_t s_q, s_d;   // skid entry, holds the single overflow entry
  entry_t in_s;
  logic   ex_ready_q, ex_ready_d;
  logic   mem_valid_q, mem_valid_d;
  logic   accept_s, drain_s;

  assign in_s     = '{alu: ex_alu_out, rs2: ex_rs2_data, rd: ex_rd,
                      reg_write: ex_reg_write, mem_read: ex_mem_read,
                      mem_write: ex_mem_write, funct3: ex_funct3};
  assign accept_s = ex_valid & ex_ready_q;
  assign drain_s  = mem_valid_q & mem_ready;

  // Next occupancy state and payload moves. A flush only empties the buffer;
  // the data registers keep their old contents because the valids guard them.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_ONE;
            h_d     = in_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && !drain_s) begin
            state_d = ST_TWO;
            s_d     = in_s;
          end else if (accept_s && drain_s) begin
            state_d = ST_ONE;
            h_d     = in_s;
          end else if (drain_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // ex_ready is low here, so only the drain side can move.
          if (drain_s) begin
            state_d = ST_ONE;
            h_d     = s_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    ex_ready_d  = (state_d != ST_TWO);
    mem_valid_d = (state_d != ST_EMPTY);
  end

  // Occupancy state, payload registers and the registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      h_q         <= '0;
      s_q         <= '0;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      s_q         <= s_d;
      ex_ready_q  <= ex_ready_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  assign ex_ready      = ex_ready_q;
  assign mem_valid     = mem_valid_q;
  assign mem_alu_out   = h_q.alu;
  assign mem_rs2_data  = h_q.rs2;
  assign mem_rd        = h_q.rd;
  assign mem_reg_write = h_q.reg_write;
  assign mem_mem_read  = h_q.mem_read;
  assign mem_mem_write = h_q.mem_write;
  assign mem_funct3    = h_q.funct3;

  // Loads have no data yet at this point and x0 is hardwired, so neither forwards.
  assign fwd_valid = mem_valid_q & h_q.reg_write & ~h_q.mem_read &
                     (h_q.rd != {REG_AW{1'b0}});
  assign fwd_rd    = h_q.rd;
  assign fwd_data  = h_q.alu;

`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles the memory stage back-pressures a valid head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else if (mem_valid_q && !mem_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
